// File: rtl/tsc_pkg.sv
// Shared types and helpers for the transient signal capture block.
package tsc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECORD    = 2'd1,
        TRIGGERED = 2'd2,
        SEND      = 2'd3
    } tsc_state_e;

    localparam int TS_W = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tsc_multi_if.sv
// ADC sample handshake: capture block requests, front end answers with rdy/dat.
interface tsc_multi_if #(parameter int DW = 8);
    logic          req;
    logic          rdy;
    logic [DW-1:0] dat;

    modport master (output req, input rdy, input dat);
    modport slave  (input req, output rdy, output dat);
endinterface

// File: rtl/tsc_ring_buf.sv
// DEPTH x DW single-port RAM, registered read with one cycle of latency; write wins.
module tsc_ring_buf
    import tsc_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic                    re_i,
    input  logic [ptr_w(DEPTH)-1:0] addr_i,
    input  logic [DW-1:0]           wdata_i,
    output logic [DW-1:0]           rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[addr_i] <= wdata_i;
        else if (re_i)
            rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/tsc_multi.sv
// Transient signal capture: pre-trigger ring buffer, post-trigger window, serial dump.
// Optional TSC_TIMESTAMP_EN adds a 16-bit trigger timestamp header to the dump.
module tsc_multi
    import tsc_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int POST  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          SBF,
    input  logic [DW-1:0] trig_lvl,
    input  logic          trig_edge,
    tsc_multi_if.master   adc,
    output logic          CD,
    output logic          TRD,
    output logic          SD,
    output logic          SD_VLD
);
    localparam int AW  = ptr_w(DEPTH);
    localparam int FW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(POST + 1);
`ifdef TSC_TIMESTAMP_EN
    localparam int SHW = (DW > TS_W) ? DW : TS_W;
`else
    localparam int SHW = DW;
`endif
    localparam int BW  = $clog2(SHW + 1);

    tsc_state_e    state_q;
    logic [AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d, ram_addr;
    logic [FW-1:0] fill_q, rcnt_q, fill_d, rcnt_d;
    logic [PW-1:0] post_q, post_d;
    logic [DW-1:0] prev_q, rdata;
    logic [SHW-1:0] sh_q, sh_ld;
    logic [BW-1:0] bits_q;
    logic          cd_q, trd_q, req_q, sd_q, sdv_q, pend_q;
    logic          acc, armed, rise, fall, hit, hdr_go, ld_smp, rd_en, send_done;
`ifdef TSC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_q;
    logic            hdr_q;
    assign hdr_go = (state_q == SEND) && hdr_q && pend_q && (bits_q == '0);
`else
    assign hdr_go = 1'b0;
`endif

    assign acc    = req_q & adc.rdy;
    assign armed  = fill_q >= FW'(DEPTH - POST);
    assign rise   = (prev_q <  trig_lvl) && (adc.dat >= trig_lvl);
    assign fall   = (prev_q >= trig_lvl) && (adc.dat <  trig_lvl);
    assign hit    = (state_q == RECORD) && acc && armed && (trig_edge ? fall : rise);
    assign wptr_d = wptr_q + 1'b1;
    assign rptr_d = rptr_q + 1'b1;
    assign rcnt_d = rcnt_q + 1'b1;
    assign post_d = post_q + 1'b1;
    assign fill_d = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + 1'b1;

    // rdata acts as a one-entry prefetch slot: refill it the cycle its sample moves into sh_q
    assign ld_smp    = (state_q == SEND) && pend_q && (bits_q == '0) && !hdr_go;
    assign rd_en     = (state_q == SEND) && (rcnt_q != FW'(DEPTH)) && (!pend_q || ld_smp);
    assign send_done = (state_q == SEND) && !pend_q && (bits_q == '0) && (rcnt_q == FW'(DEPTH));
    assign sh_ld     = SHW'(rdata) << (SHW - DW);
    assign ram_addr  = acc ? wptr_q : rptr_q;

    tsc_ring_buf #(.DW(DW), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .we_i    (acc),
        .re_i    (rd_en),
        .addr_i  (ram_addr),
        .wdata_i (adc.dat),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            rcnt_q  <= '0;
            post_q  <= '0;
            prev_q  <= '0;
            sh_q    <= '0;
            bits_q  <= '0;
            cd_q    <= 1'b0;
            trd_q   <= 1'b0;
            req_q   <= 1'b0;
            sd_q    <= 1'b0;
            sdv_q   <= 1'b0;
            pend_q  <= 1'b0;
`ifdef TSC_TIMESTAMP_EN
            ts_cnt_q <= '0;
            ts_q     <= '0;
            hdr_q    <= 1'b0;
`endif
        end else begin
            sd_q  <= 1'b0;
            sdv_q <= 1'b0;
`ifdef TSC_TIMESTAMP_EN
            ts_cnt_q <= ts_cnt_q + 1'b1;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RECORD;
                        cd_q    <= 1'b0;
                        req_q   <= 1'b1;
                        wptr_q  <= '0;
                        fill_q  <= '0;
                        prev_q  <= '0;
                    end else if (SBF && cd_q) begin
                        state_q <= SEND;
                        rptr_q  <= wptr_q;
                        rcnt_q  <= '0;
                        pend_q  <= 1'b0;
                        bits_q  <= '0;
`ifdef TSC_TIMESTAMP_EN
                        hdr_q   <= 1'b1;
`endif
                    end
                end
                RECORD, TRIGGERED: begin
                    if (acc) begin
                        wptr_q <= wptr_d;
                        fill_q <= fill_d;
                        prev_q <= adc.dat;
                    end
                    if (hit) begin
`ifdef TSC_TIMESTAMP_EN
                        ts_q <= ts_cnt_q;
`endif
                        if (POST == 1) begin
                            state_q <= IDLE;
                            cd_q    <= 1'b1;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= TRIGGERED;
                            trd_q   <= 1'b1;
                            post_q  <= PW'(1);
                        end
                    end else if (state_q == TRIGGERED && acc) begin
                        if (post_q == PW'(POST - 1)) begin
                            state_q <= IDLE;
                            cd_q    <= 1'b1;
                            trd_q   <= 1'b0;
                            req_q   <= 1'b0;
                        end else begin
                            post_q <= post_d;
                        end
                    end
                end
                SEND: begin
                    if (rd_en) begin
                        rptr_q <= rptr_d;
                        rcnt_q <= rcnt_d;
                    end
                    pend_q <= rd_en | (pend_q & ~ld_smp);
                    if (hdr_go) begin
`ifdef TSC_TIMESTAMP_EN
                        sd_q   <= ts_q[TS_W-1];
                        sh_q   <= (SHW'(ts_q) << (SHW - TS_W)) << 1;
                        bits_q <= BW'(TS_W - 1);
                        sdv_q  <= 1'b1;
                        hdr_q  <= 1'b0;
`endif
                    end else if (ld_smp) begin
                        sd_q   <= rdata[DW-1];
                        sh_q   <= sh_ld << 1;
                        bits_q <= BW'(DW - 1);
                        sdv_q  <= 1'b1;
                    end else if (bits_q != '0) begin
                        sd_q   <= sh_q[SHW-1];
                        sh_q   <= sh_q << 1;
                        bits_q <= bits_q - 1'b1;
                        sdv_q  <= 1'b1;
                    end else if (send_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc.req = req_q;
    assign CD      = cd_q;
    assign TRD     = trd_q;
    assign SD      = sd_q;
    assign SD_VLD  = sdv_q;
endmodule

// File: tb/tb_tsc_multi.sv
// Directed bench for tsc_multi: trigger modes, arming gate, serial dump, resets.
module tb_tsc_multi;
    localparam int DW = 8, DEPTH = 32, POST = 16;
    localparam logic [7:0] LVL = 8'hD6;

    logic clk = 1'b0, reset, start, SBF, trig_edge;
    logic [DW-1:0] trig_lvl, dat;
    logic CD, TRD, SD, SD_VLD;
    int checks = 0, errors = 0;
    logic [7:0] hist [$];
    logic       exp_q [$];
`ifdef TSC_TIMESTAMP_EN
    logic [15:0] tcnt, exp_ts;
    always @(posedge clk) tcnt <= reset ? 16'd0 : tcnt + 16'd1;
`endif

    always #5 clk = ~clk;

    tsc_multi_if #(.DW(DW)) adc_if ();
    assign adc_if.rdy = 1'b1;
    assign adc_if.dat = dat;

    tsc_multi #(.DW(DW), .DEPTH(DEPTH), .POST(POST)) dut (
        .clk(clk), .reset(reset), .start(start), .SBF(SBF),
        .trig_lvl(trig_lvl), .trig_edge(trig_edge), .adc(adc_if),
        .CD(CD), .TRD(TRD), .SD(SD), .SD_VLD(SD_VLD)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic feed(input logic [7:0] v);
        chk("req_during_capture", {31'd0, adc_if.req}, 1);
        dat = v;
        hist.push_back(v);
        tick();
    endtask

    task automatic arm();
        hist.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("req_after_start", {31'd0, adc_if.req}, 1);
        chk("cd_cleared_on_start", {31'd0, CD}, 0);
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, {27'd0, adc_if.req, CD, TRD, SD, SD_VLD}, 0);
    endtask

    task automatic no_vld(input string tag, input int n);
        int seen = 0;
        SBF = 1'b1;
        tick();
        SBF = 1'b0;
        repeat (n) begin
            if (SD_VLD) seen++;
            tick();
        end
        chk(tag, seen, 0);
    endtask

    // Rising capture: 0..19, crossing at D6, then 15 post samples.
    task automatic rising_capture();
        trig_edge = 1'b0;
        arm();
        for (int i = 0; i < 20; i++) feed(8'(i));
        chk("no_trd_before_cross", {31'd0, TRD}, 0);
`ifdef TSC_TIMESTAMP_EN
        exp_ts = tcnt;
`endif
        feed(LVL);
        chk("trd_on_cross", {31'd0, TRD}, 1);
        for (int i = 0; i < POST - 2; i++) feed(8'h40 + 8'(i));
        chk("trd_hold", {30'd0, TRD, CD}, 2);
        feed(8'h7E);
        chk("done_cd_trd_req", {29'd0, CD, TRD, adc_if.req}, 3'b100);
        dat = '0;
    endtask

    task automatic send_check(input string tag);
        logic [7:0] v;
        exp_q.delete();
`ifdef TSC_TIMESTAMP_EN
        for (int b = 15; b >= 0; b--) exp_q.push_back(exp_ts[b]);
`endif
        for (int k = 0; k < DEPTH; k++) begin
            v = hist[hist.size() - DEPTH + k];
            for (int b = DW - 1; b >= 0; b--) exp_q.push_back(v[b]);
        end
        SBF = 1'b1;
        tick();
        SBF = 1'b0;
        chk({tag, "_lat0"}, {31'd0, SD_VLD}, 0);
        tick();
        chk({tag, "_lat1"}, {30'd0, SD_VLD, SD}, 0);
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            tick();
            chk({tag, "_vld"}, {31'd0, SD_VLD}, 1);
            if (SD_VLD) chk({tag, "_bit"}, {31'd0, SD}, {31'd0, exp_q.pop_front()});
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        tick();
        chk({tag, "_end"}, {30'd0, SD_VLD, SD}, 0);
        chk({tag, "_cd_kept"}, {31'd0, CD}, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; SBF = 1'b0; trig_edge = 1'b0;
        trig_lvl = LVL; dat = '0;
        tick(); tick();
        reset = 1'b0;
        outs_zero("reset_outputs");
        no_vld("sbf_after_reset", 12);

        rising_capture();
        send_check("send1");
        send_check("send2");

        // Arming gate: early crossings and one at fill 15 must not fire.
        arm();
        feed(8'h00); feed(8'h00); feed(8'h00); feed(LVL);
        chk("early_cross_ignored", {31'd0, TRD}, 0);
        for (int i = 4; i < 15; i++) feed(8'h00);
        feed(LVL);
        chk("cross_at_fill15_ignored", {31'd0, TRD}, 0);
        feed(8'h00);
        feed(LVL);
        chk("cross_after_arm", {31'd0, TRD}, 1);
        for (int i = 0; i < POST - 1; i++) feed(8'h10 + 8'(i));
        chk("arm_done", {30'd0, CD, TRD}, 2);

        // Falling mode: equal samples never fire, D6 -> D5 does.
        trig_edge = 1'b1;
        arm();
        for (int i = 0; i < 20; i++) feed(LVL);
        chk("equal_no_trigger", {31'd0, TRD}, 0);
        feed(8'hD5);
        chk("falling_trigger", {31'd0, TRD}, 1);
        for (int i = 0; i < POST - 1; i++) feed(8'hA0 + 8'(i));
        chk("fall_done", {29'd0, CD, TRD, adc_if.req}, 3'b100);

        // Reset in the middle of the post-trigger window.
        trig_edge = 1'b0;
        arm();
        for (int i = 0; i < 20; i++) feed(8'(i));
        feed(LVL);
        for (int i = 0; i < 4; i++) feed(8'h55);
        chk("mid_window_trd", {31'd0, TRD}, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        outs_zero("reset_mid_window");
        no_vld("sbf_ignored_after_window_reset", 20);

        // Reset in the middle of a send.
        rising_capture();
        SBF = 1'b1; tick(); SBF = 1'b0;
        repeat (50) tick();
        chk("mid_send_vld", {31'd0, SD_VLD}, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        outs_zero("reset_mid_send");
        no_vld("sbf_ignored_after_send_reset", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
